// File: rtl/uart_tx_arbiter_2ch.sv
// Two-channel round-robin arbiter feeding a single 8N1 UART transmitter.
// Define UART_TX_ARB_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_arbiter_2ch #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 sel,
    output logic                 busy,
    output logic                 tx
);

    // state  | meaning
    // IDLE   | line high, waiting for a request; grants are issued only here
    // START  | start bit (tx=0)
    // DATA   | shift register bit 0 on tx, LSB first
    // PARITY | even parity of the latched byte (parity builds only)
    // STOP   | stop bit (tx=1)

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_ARB_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d, baud_inc;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 last_q, last_d;
    logic                 sel_d, busy_d, tx_d;
    logic                 gnt, hs0, hs1, baud_wrap;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Tie goes to the channel that did not own the previous frame.
    assign gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign hs0        = !rst && (state_q == IDLE) && req0_valid && !gnt;
    assign hs1        = !rst && (state_q == IDLE) && req1_valid && gnt;
    assign req0_ready = hs0;
    assign req1_ready = hs1;

    assign baud_wrap = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign baud_inc  = baud_wrap ? '0 : baud_q + 1'b1;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        sel_d   = sel;
`ifdef UART_TX_ARB_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (hs0 || hs1) begin
                    shreg_d = hs1 ? req1_data : req0_data;
                    sel_d   = hs1;
                    last_d  = hs1;
                    state_d = START;
`ifdef UART_TX_ARB_PARITY_EN
                    par_d   = ^shreg_d;
`endif
                end
            end
            START: begin
                baud_d = baud_inc;
                if (baud_wrap) state_d = DATA;
            end
            DATA: begin
                baud_d = baud_inc;
                if (baud_wrap) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
                baud_d = baud_inc;
                if (baud_wrap) state_d = STOP;
            end
`endif
            STOP: begin
                baud_d = baud_inc;
                if (baud_wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next-state view so the line never glitches.
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_ARB_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b1;
            sel     <= 1'b0;
            busy    <= 1'b0;
            tx      <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            sel     <= sel_d;
            busy    <= busy_d;
            tx      <= tx_d;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
